// File: rtl/baseline_pkg.sv
// Shared constants and types for the baseline tracker and its peak finder.
package baseline_pkg;

  localparam int ADC_W    = 14;
  localparam int BIN_AW   = 9;
  localparam int MAX_STEP = 8;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_SETTLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DECIDE
  } state_t;

  // Bin offset from the zero-offset bin, -255..+256.
  typedef logic signed [BIN_AW:0] offset_t;

endpackage

// File: rtl/baseline_tracker_peak_finder.sv
// Streaming peak search over tagged histogram samples; the first bin holding
// the strictly largest count wins, so ties resolve to the lowest bin index.
module peak_finder
  import baseline_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [BIN_AW-1:0] bin_i,
  input  logic [ADC_W-1:0]  count_i,
  output logic [BIN_AW-1:0] bin_o,
  output logic [ADC_W-1:0]  count_o
);

  logic [BIN_AW-1:0] bin_q, bin_d;
  logic [ADC_W-1:0]  count_q, count_d;

  always_comb begin
    bin_d   = bin_q;
    count_d = count_q;
    if (clr_i) begin
      bin_d   = '0;
      count_d = '0;
    end else if (vld_i && (count_i > count_q)) begin
      bin_d   = bin_i;
      count_d = count_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      count_q <= '0;
    end else begin
      bin_q   <= bin_d;
      count_q <= count_d;
    end
  end

  assign bin_o   = bin_q;
  assign count_o = count_q;

endmodule

// File: rtl/baseline_tracker.sv
// Baseline tracker: pauses the histogram, scans every bin for the mode and
// re-centres center_val. BASELINE_STEP_LIMIT_EN clamps each step to +/-MAX_STEP.
module baseline_tracker
  import baseline_pkg::*;
#(
  parameter int HALF_RANGE    = 255,
  parameter int UPDATE_PERIOD = 65536,
  parameter int SETTLE        = 2,
  parameter int READ_LAT      = 3,
  parameter int MIN_PEAK      = 16,
  parameter int INIT_CENTER   = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADC_W-1:0]  q_b,
  output logic              pause,
  output logic [BIN_AW-1:0] rdaddr,
  output logic [ADC_W-1:0]  center_val,
  output logic [BIN_AW-1:0] peak_bin,
  output logic [ADC_W-1:0]  peak_count,
  output logic              update_valid,
  output logic              busy
);

  // state  | meaning
  // ACCUM  | histogram accumulating; period counter advances while enable
  // SETTLE | pause held so in-flight histogram writes land
  // SCAN   | rdaddr walks 0..511
  // DRAIN  | waiting for the last read to return
  // DECIDE | latch peak, apply center correction

  localparam int CNT_W = $clog2(UPDATE_PERIOD);
  localparam int TMR_W = 8;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [BIN_AW-1:0] rdaddr_q, rdaddr_d;
  logic [ADC_W-1:0]  center_q, center_d;
  logic [BIN_AW-1:0] peak_bin_q, peak_bin_d;
  logic [ADC_W-1:0]  peak_count_q, peak_count_d;
  logic              upd_q, upd_d;
  logic              pf_clr;

  logic [READ_LAT-1:0] vld_pipe_q;
  logic [BIN_AW-1:0]   addr_pipe_q [READ_LAT];

  logic [BIN_AW-1:0]       pf_bin;
  logic [ADC_W-1:0]        pf_count;
  offset_t                 offset;
  logic signed [ADC_W+1:0] sum;
  logic [ADC_W-1:0]        center_sat;

  peak_finder u_peak (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (pf_clr),
    .vld_i  (vld_pipe_q[READ_LAT-1]),
    .bin_i  (addr_pipe_q[READ_LAT-1]),
    .count_i(q_b),
    .bin_o  (pf_bin),
    .count_o(pf_count)
  );

  always_comb begin
    offset = offset_t'({1'b0, pf_bin}) - offset_t'(HALF_RANGE);
`ifdef BASELINE_STEP_LIMIT_EN
    if (offset > offset_t'(MAX_STEP)) begin
      offset = offset_t'(MAX_STEP);
    end else if (offset < -offset_t'(MAX_STEP)) begin
      offset = -offset_t'(MAX_STEP);
    end
`endif
    // Two guard bits: bit ADC_W+1 flags underflow, bit ADC_W flags overflow.
    sum = $signed({2'b00, center_q}) + (ADC_W+2)'(offset);
    if (sum[ADC_W+1]) begin
      center_sat = '0;
    end else if (sum[ADC_W]) begin
      center_sat = '1;
    end else begin
      center_sat = sum[ADC_W-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    rdaddr_d     = rdaddr_q;
    center_d     = center_q;
    peak_bin_d   = peak_bin_q;
    peak_count_d = peak_count_q;
    upd_d        = 1'b0;
    pf_clr       = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (enable) begin
          if (cnt_q == CNT_W'(UPDATE_PERIOD-1)) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
            tmr_d   = TMR_W'(SETTLE-1);
            pf_clr  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          state_d  = ST_SCAN;
          rdaddr_d = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SCAN: begin
        if (rdaddr_q == '1) begin
          state_d  = ST_DRAIN;
          rdaddr_d = '0;
          tmr_d    = TMR_W'(READ_LAT-1);
        end else begin
          rdaddr_d = rdaddr_q + BIN_AW'(1);
        end
      end
      ST_DRAIN: begin
        if (tmr_q == '0) begin
          state_d = ST_DECIDE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_DECIDE: begin
        peak_bin_d   = pf_bin;
        peak_count_d = pf_count;
        upd_d        = 1'b1;
        if (pf_count >= ADC_W'(MIN_PEAK)) begin
          center_d = center_sat;
        end
        state_d = ST_ACCUM;
        cnt_d   = '0;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      cnt_q        <= '0;
      tmr_q        <= '0;
      rdaddr_q     <= '0;
      center_q     <= ADC_W'(INIT_CENTER);
      peak_bin_q   <= '0;
      peak_count_q <= '0;
      upd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      rdaddr_q     <= rdaddr_d;
      center_q     <= center_d;
      peak_bin_q   <= peak_bin_d;
      peak_count_q <= peak_count_d;
      upd_q        <= upd_d;
    end
  end

  // Valid tag travels with its address so each q_b sample pairs with its bin.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= (state_q == ST_SCAN);
      for (int i = 1; i < READ_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_pipe_q[0] <= rdaddr_q;
    for (int i = 1; i < READ_LAT; i++) begin
      addr_pipe_q[i] <= addr_pipe_q[i-1];
    end
  end

  assign pause        = (state_q != ST_ACCUM);
  assign busy         = (state_q != ST_ACCUM);
  assign rdaddr       = rdaddr_q;
  assign center_val   = center_q;
  assign peak_bin     = peak_bin_q;
  assign peak_count   = peak_count_q;
  assign update_valid = upd_q;

endmodule
